// File: rtl/raster_pixel_writer_if.sv
// Framebuffer write port: valid/ready request carrying a linear address and a colour.
// The master drives the request and the slave (framebuffer) drives ready.
interface raster_pixel_writer_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 12
);
  logic               fb_valid;
  logic               fb_ready;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;

  modport master (
    output fb_valid,
    output fb_addr,
    output fb_data,
    input  fb_ready
  );

  modport slave (
    input  fb_valid,
    input  fb_addr,
    input  fb_data,
    output fb_ready
  );
endinterface

// File: rtl/raster_pixel_writer.sv
// Turns the rasterizer's covered pixels into framebuffer writes: offset, clip, linearise,
// then buffer in a small FIFO that drains over a valid/ready port.
module raster_pixel_writer #(
  parameter logic [12:0] FB_WIDTH   = 13'd640,
  parameter logic [12:0] FB_HEIGHT  = 13'd480,
  parameter int          ADDR_W     = 19,
  parameter int          COLOR_W    = 12,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tile_start,
  input  logic [12:0]          offset_x,
  input  logic [12:0]          offset_y,
  input  logic [COLOR_W-1:0]   color,
  input  logic [12:0]          in_x,
  input  logic [12:0]          in_y,
  input  logic                 in_covered,
  input  logic                 raster_ready,
  raster_pixel_writer_if.master fb,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [15:0]          write_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  logic               start_accept;
  logic               done_set;
  logic               pix_accept;

  logic [12:0]        off_x;
  logic [12:0]        off_y;
  logic [COLOR_W-1:0] tile_color;

  logic [13:0]        sum_x;
  logic [13:0]        sum_y;
  logic               s1_valid;
  logic [13:0]        s1_sx;
  logic [13:0]        s1_sy;

  logic [ADDR_W-1:0]  push_addr;
  logic [ADDR_W-1:0]  mem_addr [FIFO_DEPTH];
  logic [COLOR_W-1:0] mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drop;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: state and every other sequential element use non-blocking assignments so
  // all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_set;
    end
  end

  // NOTE: every output of this block is given a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    done_set     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // The cycle that shows done is still IDLE, but a start there is refused.
        if (tile_start && !done) begin
          start_accept = 1'b1;
          state_next   = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!raster_ready) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (raster_ready) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!s1_valid && fifo_empty) begin
          done_set   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign pix_accept = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Per-tile latched parameters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      off_x      <= '0;
      off_y      <= '0;
      tile_color <= '0;
    end else if (start_accept) begin
      off_x      <= offset_x;
      off_y      <= offset_y;
      tile_color <= color;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: offset and clip. The 14-bit sums keep the carry so a wrapped
  // coordinate can never alias back onto the screen.
  // ---------------------------------------------------------------------------
  assign sum_x = {1'b0, in_x} + {1'b0, off_x};
  assign sum_y = {1'b0, in_y} + {1'b0, off_y};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sx    <= '0;
      s1_sy    <= '0;
    end else begin
      s1_valid <= pix_accept && in_covered &&
                  (sum_x < {1'b0, FB_WIDTH}) && (sum_y < {1'b0, FB_HEIGHT});
      if (pix_accept && in_covered) begin
        s1_sx <= sum_x;
        s1_sy <= sum_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: linear address, computed modulo 2^ADDR_W directly.
  // ---------------------------------------------------------------------------
  assign push_addr = ADDR_W'(s1_sy) * ADDR_W'(FB_WIDTH) + ADDR_W'(s1_sx);

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && fb.fb_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push       = s1_valid && (!fifo_full || pop);
  assign drop       = s1_valid && fifo_full && !pop;

  // NOTE: the storage array has no reset; validity lives entirely in count and the
  // pointers, and unwritten entries are never presented on the port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= tile_color;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The head only moves on a handshake, so address/data hold while stalled.
  assign fb.fb_valid = !fifo_empty;
  assign fb.fb_addr  = fifo_empty ? '0 : mem_addr[rd_ptr];
  assign fb.fb_data  = fifo_empty ? '0 : mem_data[rd_ptr];

  // ---------------------------------------------------------------------------
  // Status: sticky overflow and saturating write counter, both per tile.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow    <= 1'b0;
      write_count <= '0;
    end else begin
      if (start_accept)  overflow <= 1'b0;
      else if (drop)     overflow <= 1'b1;

      if (start_accept)                      write_count <= '0;
      else if (pop && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_raster_pixel_writer.sv
// Directed bench for raster_pixel_writer: expected framebuffer writes are queued as pixels
// are driven and compared in order whenever the DUT completes a handshake.
module tb_raster_pixel_writer;

  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 12;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } req_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               tile_start = 1'b0;
  logic [12:0]        offset_x = '0;
  logic [12:0]        offset_y = '0;
  logic [COLOR_W-1:0] color = '0;
  logic [12:0]        in_x = '0;
  logic [12:0]        in_y = '0;
  logic               in_covered = 1'b0;
  logic               raster_ready = 1'b1;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [15:0]        write_count;

  raster_pixel_writer_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) fb_if ();

  raster_pixel_writer #(
    .FB_WIDTH  (13'd640),
    .FB_HEIGHT (13'd480),
    .ADDR_W    (ADDR_W),
    .COLOR_W   (COLOR_W),
    .FIFO_DEPTH(16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .tile_start  (tile_start),
    .offset_x    (offset_x),
    .offset_y    (offset_y),
    .color       (color),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_covered  (in_covered),
    .raster_ready(raster_ready),
    .fb          (fb_if),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int   tests   = 0;
  int   failed  = 0;
  int   sb_pops = 0;
  req_t sb_q[$];

  logic [12:0]        cur_ox;
  logic [12:0]        cur_oy;
  logic [COLOR_W-1:0] cur_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one pixel: offset, clip against 640x480, row-major address.
  task automatic pixel(input int x, input int y);
    int sx, sy;
    in_x       = 13'(x);
    in_y       = 13'(y);
    in_covered = 1'b1;
    sx = x + int'(cur_ox);
    sy = y + int'(cur_oy);
    if (sx < 640 && sy < 480)
      sb_q.push_back('{addr: ADDR_W'(sy * 640 + sx), data: cur_col});
    tick();
    in_covered = 1'b0;
  endtask

  task automatic begin_tile(input logic [12:0] ox, input logic [12:0] oy,
                            input logic [COLOR_W-1:0] col);
    tile_start   = 1'b1;
    offset_x     = ox;
    offset_y     = oy;
    color        = col;
    raster_ready = 1'b1;
    in_covered   = 1'b0;
    cur_ox       = ox;
    cur_oy       = oy;
    cur_col      = col;
    tick();
    tile_start   = 1'b0;
    raster_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check(tag, done, 1);
  endtask

  // Scoreboard side: every completed handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn && fb_if.fb_valid && fb_if.fb_ready) begin
      req_t e;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
      end else begin
        e.addr = 'x;
        e.data = 'x;
      end
      check("sb_addr", fb_if.fb_addr, e.addr);
      check("sb_data", fb_if.fb_data, e.data);
      sb_pops++;
    end
  end

  initial begin
    bit saw_done;
    fb_if.fb_ready = 1'b1;
    cur_ox  = '0;
    cur_oy  = '0;
    cur_col = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_fb_valid", fb_if.fb_valid, 0);
    check("rst_fb_addr", fb_if.fb_addr, 0);
    check("rst_fb_data", fb_if.fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_write_count", write_count, 0);

    // Single covered pixel: two-cycle latency to the request
    begin_tile(13'd10, 13'd20, 12'hF00);
    check("t1_busy_rise", busy, 1);
    pixel(3, 4);
    @(negedge clk);
    check("t1_valid_lat1", fb_if.fb_valid, 0);
    tick();
    @(negedge clk);
    check("t1_valid_lat2", fb_if.fb_valid, 1);
    check("t1_addr", fb_if.fb_addr, 15373);
    check("t1_data", fb_if.fb_data, 12'hF00);
    raster_ready = 1'b1;
    tick();
    wait_done("t1_done", 20);
    check("t1_busy_fall", busy, 0);
    check("t1_write_count", write_count, 1);
    tick();
    check("t1_done_one_cycle", done, 0);

    // Clipping at the right edge
    begin_tile(13'd630, 13'd0, 12'h0AB);
    for (int i = 0; i < 16; i++) pixel(i, 0);
    raster_ready = 1'b1;
    tick();
    wait_done("t2_done", 40);
    check("t2_write_count", write_count, 10);
    check("t2_overflow", overflow, 0);
    tick();

    // Backpressure and overflow: only the first 16 survive
    fb_if.fb_ready = 1'b0;
    begin_tile(13'd0, 13'd0, 12'h123);
    for (int i = 0; i < 20; i++) pixel(i, 1);
    repeat (4) void'(sb_q.pop_back());
    raster_ready = 1'b1;
    repeat (3) tick();
    check("t3_overflow", overflow, 1);
    check("t3_held_valid", fb_if.fb_valid, 1);
    check("t3_held_addr", fb_if.fb_addr, 640);
    check("t3_no_writes", write_count, 0);
    check("t3_not_done", done, 0);
    fb_if.fb_ready = 1'b1;
    wait_done("t3_done", 60);
    check("t3_write_count", write_count, 16);
    check("t3_overflow_sticky", overflow, 1);
    tick();

    // Full FIFO with a simultaneous pop: no drop
    fb_if.fb_ready = 1'b0;
    begin_tile(13'd0, 13'd0, 12'h0F0);
    check("t4_overflow_cleared", overflow, 0);
    check("t4_count_cleared", write_count, 0);
    for (int i = 0; i < 17; i++) pixel(i, 2);
    fb_if.fb_ready = 1'b1;
    raster_ready   = 1'b1;
    tick();
    wait_done("t4_done", 60);
    check("t4_overflow", overflow, 0);
    check("t4_write_count", write_count, 17);
    tick();

    // Reset mid-drain discards pending entries without a done pulse
    fb_if.fb_ready = 1'b0;
    begin_tile(13'd0, 13'd0, 12'h321);
    for (int i = 0; i < 5; i++) pixel(i, 3);
    raster_ready = 1'b1;
    repeat (3) tick();
    fb_if.fb_ready = 1'b1;
    tick();
    fb_if.fb_ready = 1'b0;
    check("t5_pre_valid", fb_if.fb_valid, 1);
    check("t5_pre_count", write_count, 1);
    rstn = 1'b0;
    #1;
    check("t5_rst_valid", fb_if.fb_valid, 0);
    check("t5_rst_addr", fb_if.fb_addr, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_count", write_count, 0);
    sb_q.delete();
    tick();
    rstn = 1'b1;
    fb_if.fb_ready = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("t5_no_done", saw_done, 0);
    check("t5_no_write", sb_pops, 45);
    tick();

    // Start while ACTIVE is ignored; start in the done cycle is ignored
    begin_tile(13'd100, 13'd50, 12'h555);
    pixel(1, 1);
    tile_start = 1'b1;
    offset_x   = 13'd200;
    offset_y   = 13'd200;
    color      = 12'hAAA;
    tick();
    tile_start = 1'b0;
    check("t6_busy_kept", busy, 1);
    pixel(2, 2);
    raster_ready = 1'b1;
    tick();
    wait_done("t6_done", 30);
    tile_start = 1'b1;
    offset_x   = 13'd300;
    offset_y   = 13'd300;
    color      = 12'h0EE;
    tick();
    tile_start = 1'b0;
    check("t6_done_cycle_start_ignored", busy, 0);
    begin_tile(13'd5, 13'd5, 12'h777);
    check("t6_next_start_accepted", busy, 1);
    pixel(0, 0);
    raster_ready = 1'b1;
    tick();
    wait_done("t7_done", 30);
    check("t7_write_count", write_count, 1);
    tick();

    check("sb_drained", sb_q.size(), 0);
    check("sb_total_writes", sb_pops, 48);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
